mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port and its MEM-stage data port. It latches the winning request, drives the memory for a configurable number of cycles, returns read data with a one-cycle ready pulse, and produces per-port stall signals for the PC/IF-ID write enables and the later pipeline registers. It sits between the core datapath (PC, Stage3/Stage4) and the backing memory model.

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter and sequencer for one fixed-latency unified memory
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data-port priority.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          owner;      // 1 = data port owns the current access
    logic [15:0]   lat_addr;
    logic          lat_we;
    logic [31:0]   lat_wdata;
    logic          grant_dm;
    logic          access;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dm;

    // On contention, hand the grant to whichever port did not win last time.
    always_comb grant_dm = dm_req & (~if_req | ~last_dm);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dm <= 1'b0;
        end else if (state == IDLE && (if_req || dm_req)) begin
            last_dm <= grant_dm;
        end
    end
`else
    always_comb grant_dm = dm_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        owner     <= grant_dm;
                        lat_addr  <= grant_dm ? dm_addr : if_addr;
                        lat_we    <= grant_dm & dm_we;
                        lat_wdata <= grant_dm ? dm_wdata : '0;
                        cnt       <= CNT_LOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (owner) dm_rdata <= mem_rdata;
                            else       if_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign access    = (state == ACCESS);
    assign mem_en    = access;
    assign mem_we    = access & lat_we;
    assign mem_addr  = access ? lat_addr : '0;
    assign mem_wdata = access ? lat_wdata : '0;
    assign if_ready  = (state == RESP) & ~owner;
    assign dm_ready  = (state == RESP) & owner;
    assign busy      = (state != IDLE);
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - two arbiters (latency 2 and 1) on shared requests, checked against a schedule model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr;
    logic [31:0] dm_wdata;

    logic [31:0] if_rdata_o[2], dm_rdata_o[2], mem_wdata_o[2], mem_rdata_i[2];
    logic        if_ready_o[2], dm_ready_o[2], stall_if_o[2], stall_mem_o[2];
    logic        mem_en_o[2], mem_we_o[2], busy_o[2];
    logic [15:0] mem_addr_o[2];

    logic [31:0] bmem[2][64];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          lat[2] = '{2, 1};
    bit          m_act[2], m_own[2], m_we[2], m_last[2];
    int          m_g[2];
    logic [15:0] m_addr[2];
    logic [31:0] m_wd[2], m_rif[2], m_rdm[2];
    int          ph;
    bit          acc, resp, pick;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(2)) u0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[0]), .if_ready(if_ready_o[0]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_o[0]), .dm_ready(dm_ready_o[0]),
        .stall_if(stall_if_o[0]), .stall_mem(stall_mem_o[0]),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0]), .busy(busy_o[0])
    );

    mem_arbiter #(.MEM_LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[1]), .if_ready(if_ready_o[1]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_o[1]), .dm_ready(dm_ready_o[1]),
        .stall_if(stall_if_o[1]), .stall_mem(stall_mem_o[1]),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1]), .busy(busy_o[1])
    );

    assign mem_rdata_i[0] = bmem[0][mem_addr_o[0][5:0]];
    assign mem_rdata_i[1] = bmem[1][mem_addr_o[1][5:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++)
            if (mem_en_o[k] && mem_we_o[k]) bmem[k][mem_addr_o[k][5:0]] <= mem_wdata_o[k];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Schedule model: a grant decided in cycle g occupies the memory in cycles g+1..g+L and answers in g+L+1.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] = 0; m_rif[k] = '0; m_rdm[k] = '0; m_last[k] = 0;
            end
            ph   = cyc - m_g[k];
            acc  = m_act[k] && ph >= 1 && ph <= lat[k];
            resp = m_act[k] && ph == lat[k] + 1;
            chk($sformatf("u%0d_mem_en", k), mem_en_o[k], acc);
            chk($sformatf("u%0d_mem_we", k), mem_we_o[k], acc && m_we[k]);
            if (acc) chk($sformatf("u%0d_mem_addr", k), mem_addr_o[k], m_addr[k]);
            if (acc && m_we[k]) chk($sformatf("u%0d_mem_wdata", k), mem_wdata_o[k], m_wd[k]);
            chk($sformatf("u%0d_busy", k), busy_o[k], acc || resp);
            chk($sformatf("u%0d_if_ready", k), if_ready_o[k], resp && !m_own[k]);
            chk($sformatf("u%0d_dm_ready", k), dm_ready_o[k], resp && m_own[k]);
            chk($sformatf("u%0d_stall_if", k), stall_if_o[k], if_req && !(resp && !m_own[k]));
            chk($sformatf("u%0d_stall_mem", k), stall_mem_o[k], dm_req && !(resp && m_own[k]));
            chk($sformatf("u%0d_if_rdata", k), if_rdata_o[k], m_rif[k]);
            chk($sformatf("u%0d_dm_rdata", k), dm_rdata_o[k], m_rdm[k]);
            if (!rst) begin
                if (m_act[k]) begin
                    if (ph == lat[k] && !m_we[k]) begin
                        if (m_own[k]) m_rdm[k] = bmem[k][m_addr[k][5:0]];
                        else          m_rif[k] = bmem[k][m_addr[k][5:0]];
                    end
                    if (ph == lat[k] + 1) m_act[k] = 0;
                end else if (if_req || dm_req) begin
                    if (if_req && dm_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        pick = !m_last[k];
`else
                        pick = 1;
`endif
                    end else begin
                        pick = dm_req;
                    end
                    m_act[k]  = 1;
                    m_g[k]    = cyc;
                    m_own[k]  = pick;
                    m_addr[k] = pick ? dm_addr : if_addr;
                    m_we[k]   = pick && dm_we;
                    m_wd[k]   = dm_wdata;
                    m_last[k] = pick;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) bmem[k][i] = 32'hA500_0000 + i;
        bmem[0][4] = 32'h8C22_0000;
        bmem[1][4] = 32'h8C22_0000;
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        step(2);
        chk("rst_mem_en", mem_en_o[0], 0);
        chk("rst_busy", busy_o[1], 0);
        chk("rst_if_rdata", if_rdata_o[0], 0);
        rst = 1'b0;
        step(2);

        // single fetch
        if_req = 1; if_addr = 16'h0004;
        #1 chk("t1_stall_c0", stall_if_o[0], 1); chk("t1_en_c0", mem_en_o[0], 0);
        step; #1 chk("t1_en_c1", mem_en_o[0], 1); chk("t1_addr_c1", mem_addr_o[0], 16'h0004);
        step; #1 chk("t1_en_c2", mem_en_o[0], 1); chk("t1_stall_c2", stall_if_o[0], 1);
        step; #1 chk("t1_ready_c3", if_ready_o[0], 1); chk("t1_rdata_c3", if_rdata_o[0], 32'h8C22_0000);
        chk("t1_stall_c3", stall_if_o[0], 0); chk("t1_en_c3", mem_en_o[0], 0);
        if_req = 0;
        step; #1 chk("t1_busy_c4", busy_o[0], 0);
        step(5);

        // data write, address/data changed while granted
        dm_req = 1; dm_we = 1; dm_addr = 16'h0010; dm_wdata = 32'hDEAD_BEEF;
        step; #1 chk("t2_we_c1", mem_we_o[0], 1); chk("t2_addr_c1", mem_addr_o[0], 16'h0010);
        chk("t2_wdata_c1", mem_wdata_o[0], 32'hDEAD_BEEF);
        dm_addr = 16'h0020; dm_wdata = 32'h1234_5678;
        step; #1 chk("t2_we_c2", mem_we_o[0], 1); chk("t2_addr_c2", mem_addr_o[0], 16'h0010);
        chk("t2_wdata_c2", mem_wdata_o[0], 32'hDEAD_BEEF);
        step; #1 chk("t2_ready_c3", dm_ready_o[0], 1); chk("t2_rdata_c3", dm_rdata_o[0], 0);
        dm_req = 0; dm_we = 0;
        step(5);

        // read back the written word
        dm_req = 1; dm_addr = 16'h0010;
        step(3); #1 chk("t2b_ready", dm_ready_o[0], 1); chk("t2b_rdata", dm_rdata_o[0], 32'hDEAD_BEEF);
        dm_req = 0;
        step(5);

        // contention: data first, then fetch
        if_req = 1; if_addr = 16'h0008; dm_req = 1; dm_addr = 16'h0011;
        step; #1 chk("t3_addr_c1", mem_addr_o[0], 16'h0011);
        step(2); #1 chk("t3_dready_c3", dm_ready_o[0], 1); chk("t3_stall_if_c3", stall_if_o[0], 1);
        chk("t3_drdata_c3", dm_rdata_o[0], 32'hA500_0011);
`ifndef MEM_ARB_ROUND_ROBIN_EN
        dm_req = 0;
`endif
        step; #1 chk("t3_busy_c4", busy_o[0], 0);
        step; #1 chk("t3_addr_c5", mem_addr_o[0], 16'h0008);
        step(2); #1 chk("t3_iready_c7", if_ready_o[0], 1); chk("t3_irdata_c7", if_rdata_o[0], 32'hA500_0008);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        step(4); #1 chk("t3_dready_c11", dm_ready_o[0], 1); chk("t3_stall_if_c11", stall_if_o[0], 1);
        step(4); #1 chk("t3_iready_c15", if_ready_o[0], 1);
`endif
        if_req = 0; dm_req = 0;
        step(5);

        // reset in the middle of an access
        if_req = 1; if_addr = 16'h0004;
        step; #1 chk("t4_en_c1", mem_en_o[0], 1);
        rst = 1'b1;
        #1 chk("t4_en_rst", mem_en_o[0], 0); chk("t4_busy_rst", busy_o[0], 0);
        chk("t4_ready_rst", if_ready_o[0], 0); chk("t4_rdata_rst", if_rdata_o[0], 0);
        step(2);
        rst = 1'b0;
        step(3); #1 chk("t4_ready_r3", if_ready_o[0], 1); chk("t4_rdata_r3", if_rdata_o[0], 32'h8C22_0000);
        if_req = 0;
        step(6);

        // latency-1 instance, fetch held continuously
        if_req = 1; if_addr = 16'h0003;
        step(2); #1 chk("t5_ready_c2", if_ready_o[1], 1); chk("t5_rdata_c2", if_rdata_o[1], 32'hA500_0003);
        step; #1 chk("t5_ready_c3", if_ready_o[1], 0);
        step(2); #1 chk("t5_ready_c5", if_ready_o[1], 1);
        step(3); #1 chk("t5_ready_c8", if_ready_o[1], 1); chk("t5_rdata_c8", if_rdata_o[1], 32'hA500_0003);
        if_req = 0;
        step(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
